// File: rtl/vliw_pkg.sv
// Shared types and slot field positions for the VLIW bundle fetch path.
package vliw_pkg;

  localparam int NSLOTS_C = 10;
  localparam int SLOT_W_C = 32;
  localparam int BUNDLE_W = NSLOTS_C * SLOT_W_C;

  typedef logic [BUNDLE_W-1:0] bundle_t;

  // Field positions inside one slot instruction word.
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS1_HI = 21;
  localparam int RS1_LO = 17;
  localparam int RS2_HI = 16;
  localparam int RS2_LO = 12;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 0;

  function automatic logic [SLOT_W_C-1:0] get_slot(input bundle_t b, input int unsigned idx);
    return b[idx*SLOT_W_C +: SLOT_W_C];
  endfunction

endpackage

// File: rtl/bundle_fifo.sv
// In-order prefetch buffer of {pc, bundle} entries with a flush and a
// head output that reads zero whenever the buffer is empty.
module bundle_fifo #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int DATA_W = 320
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [PC_W-1:0]            push_pc,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [PC_W-1:0]            head_pc,
  output logic [DATA_W-1:0]          head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]   pc_mem_q   [DEPTH];
  logic [PC_W-1:0]   pc_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

  // Head reads straight from storage flops; gated so an empty buffer shows zero.
  assign head_pc   = empty ? '0 : pc_mem_q[rd_ptr_q];
  assign head_data = empty ? '0 : data_mem_q[rd_ptr_q];

  always_comb begin
    do_pop     = pop && !empty;
    pc_mem_d   = pc_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = push_pc;
        data_mem_d[wr_ptr_q] = push_data;
        wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule

// File: rtl/vliw_bundle_fetch.sv
// Bundle fetch: credit-limited imem requests, redirect drop accounting and prefetch buffer.
// Optional SLOT_MASK_EN: slot_valid flags non-zero slot words instead of mirroring issue_valid.
module vliw_bundle_fetch
  import vliw_pkg::*;
#(
  parameter int NSLOTS = NSLOTS_C,
  parameter int SLOT_W = SLOT_W_C,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [NSLOTS*SLOT_W-1:0]   imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [NSLOTS*SLOT_W-1:0]   issue_bundle,
  output logic [ADDR_W-1:0]          issue_pc,
  output logic [NSLOTS-1:0]          slot_valid
);

  localparam int BW    = NSLOTS * SLOT_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  occ;
  logic              fifo_full, fifo_empty;
  logic              req_fire, rsp_fire, rsp_keep, push, pop;

  // Buffered plus in-flight bundles never exceed DEPTH, so a response always has a slot.
  assign imem_req_valid = !rst &&
    ((CNT_W+1)'(occ) + (CNT_W+1)'(outst_q) < (CNT_W+1)'(DEPTH));
  assign imem_req_addr  = rst ? '0 : pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (outst_q != '0);
  assign rsp_keep = rsp_fire && (drop_q == '0);
  assign push     = rsp_keep && !redirect_valid;
  assign pop      = issue_ready && !redirect_valid;

  assign issue_valid = !fifo_empty;

  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    if (rsp_fire && !rsp_keep) begin
      drop_d = drop_q - CNT_W'(1);
    end
    if (req_fire) begin
      pc_d = pc_q + ADDR_W'(1);
    end
    // Everything still in flight after this edge belongs to the old path.
    if (redirect_valid) begin
      pc_d   = redirect_pc;
      drop_d = outst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && fifo_full && !pop));
    end
  end

  bundle_fifo #(
    .DEPTH  (DEPTH),
    .PC_W   (ADDR_W),
    .DATA_W (BW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_pc   (pc_q_of_rsp()),
    .push_data (imem_rsp_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ),
    .head_pc   (issue_pc),
    .head_data (issue_bundle)
  );

  // Address of the response being accepted: pc minus everything still in flight.
  function automatic logic [ADDR_W-1:0] pc_q_of_rsp();
    return pc_q - ADDR_W'(outst_q);
  endfunction

`ifdef SLOT_MASK_EN
  always_comb begin
    slot_valid = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      slot_valid[i] = (issue_bundle[i*SLOT_W +: SLOT_W] != '0);
    end
  end
`else
  assign slot_valid = {NSLOTS{issue_valid}};
`endif

endmodule

// File: tb/tb_vliw_bundle_fetch.sv
// Randomized bench for vliw_bundle_fetch against an epoch-tagged memory/stream model.
module tb_vliw_bundle_fetch;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_rsp_valid;
  logic [319:0] imem_rsp_data;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         issue_valid;
  logic         issue_ready;
  logic [319:0] issue_bundle;
  logic [31:0]  issue_pc;
  logic [9:0]   slot_valid;

  vliw_bundle_fetch #(.NSLOTS(10), .SLOT_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_bundle   (issue_bundle),
    .issue_pc       (issue_pc),
    .slot_valid     (slot_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          t;
  } mreq_t;

  mreq_t       memq[$];
  logic [31:0] m_buf[$];
  logic [31:0] m_pc;
  int          m_ep;
  int          last_t;
  int          cyc;

  int          n_chk = 0;
  int          n_err = 0;

  int          p_req_rdy, p_iss_rdy, p_rsp, p_redir, lat_min, lat_max;
  bit          f_rst, f_redir, f_stale;
  logic [31:0] f_pc;
  bit          track, saw;
  logic [31:0] first_pc;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit draw(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Memory contents: a fixed function of the bundle address, with some NOP slots.
  function automatic logic [319:0] bdata(input logic [31:0] a);
    logic [319:0] b;
    b = '0;
    if (a == 32'd3) begin
      b[5*32 +: 32] = 32'h4A043000;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (((a + 32'(i)) % 3) != 0)
          b[i*32 +: 32] = (a * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B) ^ 32'h1;
      end
    end
    return b;
  endfunction

  function automatic logic [9:0] smask(input logic [319:0] b, input bit v);
    logic [9:0] m;
    m = '0;
`ifdef SLOT_MASK_EN
    for (int i = 0; i < 10; i++) m[i] = v && (b[i*32 +: 32] != 32'd0);
`else
    m = {10{v}};
`endif
    return m;
  endfunction

  task automatic cycle();
    bit           exp_rv, exp_iv, rq, iq, rs;
    logic [319:0] eb;
    mreq_t        r;
    int           tt;
    @(negedge clk);
    rst            = f_rst;
    imem_req_ready = f_stale ? 1'b0 : draw(p_req_rdy);
    issue_ready    = draw(p_iss_rdy);
    rs = 1'b0;
    if (f_stale) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = {10{$urandom()}};
    end else if (memq.size() > 0 && memq[0].t <= cyc && draw(p_rsp)) begin
      rs = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = bdata(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = {10{$urandom()}};
    end
    if (f_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = f_pc;
    end else if (draw(p_redir)) begin
      redirect_valid = 1'b1;
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFE + 32'($urandom_range(0, 1)) : $urandom();
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom();
    end
    f_redir = 1'b0;
    f_stale = 1'b0;
    #1;
    exp_rv = !rst && (m_buf.size() + memq.size() < DEPTH);
    exp_iv = (m_buf.size() != 0);
    eb     = exp_iv ? bdata(m_buf[0]) : '0;
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, rst ? 32'd0 : m_pc);
    chk("issue_valid", issue_valid, exp_iv);
    chk("issue_pc", issue_pc, exp_iv ? m_buf[0] : 32'd0);
    chk("issue_bundle", issue_bundle, eb);
    chk("slot_valid", slot_valid, smask(eb, exp_iv));
    if (track && !saw && issue_valid && issue_ready && !redirect_valid) begin
      saw = 1'b1;
      first_pc = issue_pc;
    end
    rq = exp_rv && imem_req_ready;
    iq = exp_iv && issue_ready;
    if (rst) begin
      m_buf.delete();
      memq.delete();
      m_pc = '0;
      m_ep++;
      last_t = 0;
    end else begin
      if (iq) void'(m_buf.pop_front());
      if (rs) begin
        r = memq.pop_front();
        if (!redirect_valid && r.ep == m_ep) m_buf.push_back(r.addr);
      end
      if (rq) begin
        tt = cyc + $urandom_range(lat_min, lat_max);
        if (tt < last_t) tt = last_t;
        last_t = tt;
        memq.push_back('{addr: m_pc, ep: m_ep, t: tt});
      end
      if (redirect_valid) begin
        m_buf.delete();
        m_ep++;
        m_pc = redirect_pc;
      end else if (rq) begin
        m_pc = m_pc + 32'd1;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; issue_ready = 1'b0;
    m_pc = '0; m_ep = 0; last_t = 0; cyc = 0;
    p_req_rdy = 100; p_iss_rdy = 0; p_rsp = 0; p_redir = 0; lat_min = 2; lat_max = 2;
    f_rst = 1'b1; f_redir = 1'b0; f_stale = 1'b0; f_pc = '0; track = 1'b0; saw = 1'b0; first_pc = '0;
    @(posedge clk);

    // Reset held, then requests 0..3 back to back until the credit runs out.
    repeat (3) cycle();
    f_rst = 1'b0;
    repeat (6) cycle();
    // Responses fill the buffer with decode stalled, then drain with no gaps.
    p_rsp = 100;
    repeat (6) cycle();
    track = 1'b1; saw = 1'b0;
    p_iss_rdy = 100;
    repeat (12) cycle();
    chk("first_issue_pc", first_pc, saw ? 32'd0 : 32'hDEAD);
    track = 1'b0;

    // Redirect with three outstanding, then a second redirect one cycle later.
    f_rst = 1'b1; cycle(); f_rst = 1'b0;
    p_rsp = 0; p_req_rdy = 100;
    repeat (3) cycle();
    p_req_rdy = 0;
    f_redir = 1'b1; f_pc = 32'd40; cycle();
    p_req_rdy = 100;
    f_redir = 1'b1; f_pc = 32'd80; cycle();
    track = 1'b1; saw = 1'b0;
    p_rsp = 100;
    repeat (20) cycle();
    chk("redirect_first_pc", saw ? first_pc : 32'hDEAD, 32'd80);
    track = 1'b0;

    // PC wrap, then reset mid-stream with a stray response right after.
    f_redir = 1'b1; f_pc = 32'hFFFFFFFF; cycle();
    lat_min = 1; lat_max = 3;
    repeat (12) cycle();
    f_rst = 1'b1; cycle(); f_rst = 1'b0;
    f_stale = 1'b1; cycle();
    repeat (12) cycle();

    // Randomized mix of stalls, latencies and redirects.
    p_req_rdy = 70; p_iss_rdy = 70; p_rsp = 70; p_redir = 3; lat_min = 1; lat_max = 4;
    repeat (3000) cycle();
    p_req_rdy = 100; p_iss_rdy = 100; p_rsp = 100; p_redir = 0; lat_min = 1; lat_max = 3;
    repeat (200) cycle();
    p_iss_rdy = 50; p_redir = 5;
    repeat (1000) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
